// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and line-level constants shared by the I2C target
package i2c_pkg;
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_t;
    localparam int   RW_BIT = 0;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
endpackage

// File: rtl/i2c_line_cond.sv
// i2c_line_cond: SCL/SDA synchronizers, optional majority filter (I2C_TARGET_GLITCH_FILTER_EN), line events
module i2c_line_cond
    import i2c_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_lvl_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_c, sda_c, scl_prev_q, sda_prev_q;
    // two-flop synchronizers, reset to the idle-high bus level so no event fires out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_maj_q, sda_maj_q;
    // majority vote over three consecutive samples rejects single-clock pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_maj_q  <= 1'b1;
            sda_maj_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_maj_q  <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[1]);
            sda_maj_q  <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[1]);
        end
    end
    assign scl_c = scl_maj_q;
    assign sda_c = sda_maj_q;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif
    // previous conditioned levels for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end
    assign sda_lvl_o  = sda_c;
    assign scl_rise_o = scl_c & ~scl_prev_q;
    assign scl_fall_o = ~scl_c & scl_prev_q;
    assign start_o    = scl_c & scl_prev_q & ~sda_c & sda_prev_q;
    assign stop_o     = scl_c & scl_prev_q & sda_c & ~sda_prev_q;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with a byte register file shared with a Wishbone-style bus port (filter: I2C_TARGET_GLITCH_FILTER_EN)
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h1A,
    parameter int         NREGS = 16,
    localparam int        AW    = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    input  logic [AW-1:0] adr_i,
    input  logic [7:0]    dat_i,
    output logic [7:0]    dat_o,
    input  logic          we_i,
    input  logic          stb_i,
    input  logic          cyc_i,
    output logic          ack_o,
    output logic          busy,
    output logic          wr_strobe
);
    i2c_state_t    state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          sda_q, sda_d;
    logic          commit, wr_strobe_q, ack_q, req;
    logic [7:0]    dat_q;
    logic [7:0]    regs_q [NREGS];
    logic          sda_lvl, start, stop, rise, fall;

    i2c_line_cond u_cond (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_lvl_o  (sda_lvl),
        .start_o    (start),
        .stop_o     (stop),
        .scl_rise_o (rise),
        .scl_fall_o (fall)
    );

    // protocol state register; reset releases SDA and drops any partial byte
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            ptr_q   <= '0;
            sda_q   <= NACK;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            sda_q   <= sda_d;
        end
    end

    // bits shift in on SCL rise; SDA and state advance on SCL fall
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        sda_d   = sda_q;
        commit  = 1'b0;
        if (start) begin
            state_d = ST_ADDR;
            bit_d   = '0;
            sda_d   = NACK;
        end else if (stop) begin
            state_d = ST_IDLE;
            sda_d   = NACK;
        end else if (rise) begin
            if (state_q inside {ST_ADDR, ST_PTR, ST_WDATA}) begin
                shift_d = {shift_q[6:0], sda_lvl};
                bit_d   = bit_q + 4'd1;
            end else if (state_q == ST_RDATA) begin
                bit_d = bit_q + 4'd1;
            end else if (state_q == ST_RDATA_ACK && sda_lvl == NACK) begin
                state_d = ST_IGNORE;
            end
        end else if (fall) begin
            case (state_q)
                ST_ADDR: if (bit_q == 4'd8) begin
                    state_d = (shift_q[7:1] == ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                    sda_d   = (shift_q[7:1] == ADDR) ? ACK : NACK;
                end
                ST_ADDR_ACK: begin
                    bit_d   = '0;
                    state_d = shift_q[RW_BIT] ? ST_RDATA : ST_PTR;
                    shift_d = shift_q[RW_BIT] ? regs_q[ptr_q] : shift_q;
                    sda_d   = shift_q[RW_BIT] ? regs_q[ptr_q][7] : NACK;
                end
                ST_PTR: if (bit_q == 4'd8) begin
                    ptr_d   = shift_q[AW-1:0];
                    state_d = ST_PTR_ACK;
                    sda_d   = ACK;
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    state_d = ST_WDATA;
                    bit_d   = '0;
                    sda_d   = NACK;
                end
                ST_WDATA: if (bit_q == 4'd8) begin
                    commit  = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    state_d = ST_WDATA_ACK;
                    sda_d   = ACK;
                end
                ST_RDATA: if (bit_q == 4'd8) begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = ST_RDATA_ACK;
                    sda_d   = NACK;
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                    sda_d   = shift_q[6];
                end
                ST_RDATA_ACK: begin
                    bit_d   = '0;
                    state_d = ST_RDATA;
                    shift_d = regs_q[ptr_q];
                    sda_d   = regs_q[ptr_q][7];
                end
                default: ;
            endcase
        end
    end

    assign req = stb_i & cyc_i & ~ack_q;

    // register file and bus port; the I2C commit is written last so it wins a same-register collision
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            wr_strobe_q <= 1'b0;
        end else begin
            ack_q       <= req;
            wr_strobe_q <= commit;
            if (req) dat_q <= regs_q[adr_i];
            if (req && we_i) regs_q[adr_i] <= dat_i;
            if (commit) regs_q[ptr_q] <= shift_q;
        end
    end

    assign sda_o     = sda_q;
    assign ack_o     = ack_q;
    assign dat_o     = dat_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C and bus transactions against hand-computed expectations
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int LAT  = 4;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit FILT = 1'b0;
`endif
    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
    logic       sda_o, ack_o, busy, wr_strobe, line;
    logic       stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] adr = '0;
    logic [7:0] dat_w = '0, dat_o;
    int         checks = 0, passed = 0, ws_cnt = 0, low_cnt = 0;

    assign line = sda_m & sda_o;
    always #5 clk = ~clk;

    i2c_target dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl),
        .sda_i     (line),
        .sda_o     (sda_o),
        .adr_i     (adr),
        .dat_i     (dat_w),
        .dat_o     (dat_o),
        .we_i      (we),
        .stb_i     (stb),
        .cyc_i     (cyc),
        .ack_o     (ack_o),
        .busy      (busy),
        .wr_strobe (wr_strobe)
    );

    // running counts of strobe cycles and cycles with SDA driven low
    always @(posedge clk) begin
        if (wr_strobe) ws_cnt <= ws_cnt + 1;
        if (!sda_o) low_cnt <= low_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;
        wait_clk(10);
        scl = 1'b1;
        wait_clk(5);
        r = line;
        wait_clk(5);
        scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wait_clk(10);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(2);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wait_clk(10);
        scl = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(~ack, r);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        adr = a; dat_w = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        wait_clk(1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        wait_clk(1);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        wait_clk(1);
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
        wait_clk(1);
    endtask

    // data byte whose commit clock is met by a bus write of 0x77 to reg 2
    task automatic send_collide(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 1; i--) bit_x(b[i], r);
        sda_m = b[0];
        wait_clk(10);
        scl = 1'b1;
        wait_clk(10);
        scl = 1'b0;
        wait_clk(LAT);
        adr = 4'd2; dat_w = 8'h77; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        wait_clk(1);
        check("col_ack_hi", ack_o, 1);
        check("col_strobe", wr_strobe, 1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        wait_clk(1);
        check("col_ack_lo", ack_o, 0);
        bit_x(1'b1, r);
        ack = ~r;
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        int         ws0, lo0;
        wait_clk(3);
        check("rst_sda", sda_o, 1);
        check("rst_ack", ack_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", wr_strobe, 0);
        rst = 1'b0;
        wait_clk(3);

        ws0 = ws_cnt;
        start_c();
        send_byte(8'h34, ack); check("wr_addr_ack", ack, 1);
        check("wr_busy", busy, 1);
        send_byte(8'h03, ack); check("wr_ptr_ack", ack, 1);
        send_byte(8'hA5, ack); check("wr_d0_ack", ack, 1);
        send_byte(8'h5A, ack); check("wr_d1_ack", ack, 1);
        stop_c();
        check("wr_idle", busy, 0);
        check("wr_strobes", ws_cnt - ws0, 2);
        bus_rd(4'd3, d); check("wr_reg3", d, 8'hA5);
        bus_rd(4'd4, d); check("wr_reg4", d, 8'h5A);

        bus_wr(4'd15, 8'hC3);
        bus_wr(4'd0, 8'h3C);
        start_c();
        send_byte(8'h34, ack); check("rd_addr_ack", ack, 1);
        send_byte(8'h0F, ack); check("rd_ptr_ack", ack, 1);
        start_c();
        send_byte(8'h35, ack); check("rd_addrr_ack", ack, 1);
        read_byte(1'b1, d); check("rd_reg15", d, 8'hC3);
        read_byte(1'b0, d); check("rd_reg0_wrap", d, 8'h3C);
        check("rd_state", dut.state_q, ST_IGNORE);
        check("rd_sda", sda_o, 1);
        check("rd_busy", busy, 0);
        stop_c();

        lo0 = low_cnt;
        ws0 = ws_cnt;
        start_c();
        send_byte(8'h44, ack); check("na_ack", ack, 0);
        check("na_busy", busy, 0);
        send_byte(8'h99, ack); check("na_data_ack", ack, 0);
        stop_c();
        check("na_sda_low", low_cnt - lo0, 0);
        check("na_strobes", ws_cnt - ws0, 0);
        bus_rd(4'd3, d); check("na_reg3", d, 8'hA5);

        ws0 = ws_cnt;
        start_c();
        send_byte(8'h34, ack); check("col_addr_ack", ack, 1);
        send_byte(8'h02, ack); check("col_ptr_ack", ack, 1);
        send_collide(8'h11, ack); check("col_d_ack", ack, 1);
        stop_c();
        check("col_strobes", ws_cnt - ws0, 1);
        bus_rd(4'd2, d); check("col_reg2", d, 8'h11);

        start_c();
        send_byte(8'h34, ack); check("rs_addr_ack", ack, 1);
        send_byte(8'h03, ack); check("rs_ptr_ack", ack, 1);
        for (int i = 0; i < 3; i++) bit_x(1'b0, r);
        sda_m = 1'b1;
        wait_clk(10);
        scl = 1'b1;
        wait_clk(3);
        #2 rst = 1'b1;
        #1;
        check("rs_sda", sda_o, 1);
        check("rs_busy", busy, 0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        bus_rd(4'd3, d); check("rs_reg3", d, 0);
        bus_rd(4'd4, d); check("rs_reg4", d, 0);
        bus_rd(4'd15, d); check("rs_reg15", d, 0);
        bus_rd(4'd2, d); check("rs_reg2", d, 0);
        start_c();
        send_byte(8'h34, ack); check("rs_readdr_ack", ack, 1);
        stop_c();

        start_c();
        send_byte(8'h34, ack); check("gl_addr_ack", ack, 1);
        check("gl_busy_pre", busy, 1);
        sda_m = 1'b1;
        wait_clk(10);
        scl = 1'b1;
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(1);
        sda_m = 1'b1;
        wait_clk(10);
        check("gl_busy_post", busy, FILT);
        scl = 1'b0;
        wait_clk(2);
        stop_c();
        check("gl_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
